bcd_down_timer: RTL and testbench

Multi-digit BCD countdown timer: the decrementing counterpart to the team's cascaded up-counters, used wherever a preset time or event budget must run down to zero (display countdowns, timeouts). It loads a BCD preset, decrements it once per prescaled tick under a small run/pause state machine, and flags expiry. It sits beside the up-counter chains and feeds the same display/decoder path.

---
 rtl/bcd_down_timer.sv | 88 ++++++++
 tb/tb_bcd_down_timer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: loadable BCD countdown with prescaled ticks, run/pause FSM and expiry flag
module bcd_down_timer #(
  parameter int DIGITS = 4,
  parameter int PRESCALE = 1000,
  parameter int PW = 10
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  load,
  input  logic                  start,
  input  logic                  pause,
  input  logic [4*DIGITS-1:0]   preset,
  output logic [4*DIGITS-1:0]   value,
  output logic                  running,
  output logic                  done,
  output logic                  done_pulse
);
  localparam int W = 4*DIGITS;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state;
  logic [PW-1:0] presc;
  logic tick;
  function automatic logic [W-1:0] clamp9(input logic [W-1:0] p);
    for (int i = 0; i < DIGITS; i++)
      clamp9[4*i+:4] = p[4*i+:4] > 4'd9 ? 4'd9 : p[4*i+:4];
  endfunction
  // borrow ripples upward through every digit that was 0
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic b;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_dec[4*i+:4] = b ? (v[4*i+:4] == 4'd0 ? 4'd9 : v[4*i+:4] - 4'd1) : v[4*i+:4];
      b = b && v[4*i+:4] == 4'd0;
    end
  endfunction
  assign tick = presc == PW'(PRESCALE-1);
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state <= IDLE;
      value <= '0;
      presc <= '0;
      running <= 1'b0;
      done <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (load) begin
        state <= IDLE;
        value <= clamp9(preset);
        presc <= '0;
        running <= 1'b0;
        done <= 1'b0;
      end else
        case (state)
          IDLE:
            if (start && value == '0) begin
              state <= DONE;
              done <= 1'b1;
              done_pulse <= 1'b1;
            end else if (start) begin
              state <= RUN;
              running <= 1'b1;
              presc <= '0;
            end
          RUN:
            if (pause) begin
              state <= PAUSE;
              running <= 1'b0;
            end else if (tick) begin
              presc <= '0;
              value <= bcd_dec(value);
              if (value == W'(1)) begin
                state <= DONE;
                running <= 1'b0;
                done <= 1'b1;
                done_pulse <= 1'b1;
              end
            end else
              presc <= presc + PW'(1);
          PAUSE:
            if (start && !pause) begin
              state <= RUN;
              running <= 1'b1;
            end
          DONE: ;
        endcase
    end
endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed checks of countdown, borrow, pause/resume, priority and async reset
module tb_bcd_down_timer;
  logic clk = 1'b0, clr_n = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] preset = '0, value;
  logic running, done, done_pulse;
  int n_tests = 0, n_fail = 0;
  bcd_down_timer #(.DIGITS(2), .PRESCALE(4), .PW(3)) dut (
    .clk(clk), .clr_n(clr_n), .load(load), .start(start), .pause(pause),
    .preset(preset), .value(value), .running(running), .done(done), .done_pulse(done_pulse)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_load(input logic [7:0] p);
    preset = p;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask
  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 0;
  endtask
  initial begin
    #1;
    chk("rst_value", value, 8'h00);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_pulse", done_pulse, 0);
    cyc(1);
    clr_n = 1'b1;
    cyc(1);
    do_load(8'h03);
    chk("load03", value, 8'h03);
    chk("load_idle", running, 0);
    do_start();
    chk("start_run", running, 1);
    cyc(3);
    chk("n3_value", value, 8'h03);
    cyc(1);
    chk("n4_value", value, 8'h02);
    cyc(4);
    chk("n8_value", value, 8'h01);
    cyc(3);
    chk("n11_done", done, 0);
    cyc(1);
    chk("n12_value", value, 8'h00);
    chk("n12_done", done, 1);
    chk("n12_pulse", done_pulse, 1);
    chk("n12_running", running, 0);
    cyc(1);
    chk("n13_pulse", done_pulse, 0);
    chk("n13_done", done, 1);
    do_start();
    chk("done_start_done", done, 1);
    chk("done_start_run", running, 0);
    chk("done_start_val", value, 8'h00);
    do_load(8'h10);
    do_start();
    cyc(4);
    chk("borrow_09", value, 8'h09);
    cyc(4);
    chk("borrow_08", value, 8'h08);
    start = 1'b1;
    do_load(8'h9A);
    start = 1'b0;
    chk("load_start_val", value, 8'h99);
    chk("load_start_run", running, 0);
    cyc(5);
    chk("idle_hold", value, 8'h99);
    do_load(8'h02);
    do_start();
    cyc(2);
    pause = 1'b1;
    cyc(1);
    chk("pause_run", running, 0);
    chk("pause_val", value, 8'h02);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("pause_start_held", running, 0);
    cyc(2);
    pause = 1'b0;
    do_start();
    chk("resume_run", running, 1);
    cyc(1);
    chk("resume_n9", value, 8'h02);
    cyc(1);
    chk("resume_n10", value, 8'h01);
    cyc(3);
    chk("resume_n13_done", done, 0);
    cyc(1);
    chk("resume_n14_val", value, 8'h00);
    chk("resume_n14_done", done_pulse, 1);
    do_load(8'h05);
    do_start();
    cyc(1);
    start = 1'b1;
    pause = 1'b1;
    cyc(1);
    start = 1'b0;
    pause = 1'b0;
    chk("start_pause_run", running, 0);
    cyc(6);
    chk("start_pause_val", value, 8'h05);
    do_load(8'h00);
    do_start();
    chk("zero_done", done, 1);
    chk("zero_pulse", done_pulse, 1);
    chk("zero_val", value, 8'h00);
    do_load(8'h25);
    do_start();
    cyc(4);
    chk("pre_rst_val", value, 8'h24);
    #2 clr_n = 1'b0;
    #1;
    chk("async_val", value, 8'h00);
    chk("async_run", running, 0);
    chk("async_done", done, 0);
    cyc(1);
    clr_n = 1'b1;
    cyc(8);
    chk("post_rst_val", value, 8'h00);
    chk("post_rst_run", running, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout: got running expected finish");
    $fatal(1);
  end
endmodule
